// File: rtl/loopback_csr_pkg.sv
// Shared constants and FSM encoding for the loopback CSR sequencer.
package loopback_csr_pkg;

  localparam int unsigned LB_CSR_DW = 32;

  localparam logic [3:0] LB_ADDR_CTRL_WR = 4'd1;
  localparam logic [3:0] LB_ADDR_CTRL_RD = 4'd0;
  localparam logic [3:0] LB_ADDR_PLL     = 4'd1;
  localparam logic [3:0] LB_ADDR_LTR     = 4'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CTRL,
    S_RD_CTRL,
    S_WT_CTRL,
    S_RD_PLL,
    S_WT_PLL,
    S_RD_LTR,
    S_WT_LTR,
    S_GAP,
    S_FIN
  } lb_state_e;

endpackage

// File: rtl/lb_cycle_counter.sv
// Loadable saturating up-counter; at_term is high once the count reaches term_val.
module lb_cycle_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic             at_term
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q >= term_val);

endmodule

// File: rtl/loopback_csr_sequencer.sv
// Avalon-MM initiator: writes/verifies the loopback control word, then polls lock status.
// Strobes are decoded from the state register so they drop with the asynchronous reset.
module loopback_csr_sequencer
  import loopback_csr_pkg::*;
#(
  parameter int unsigned NUM_OF_CH      = 1,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 lpbk_en,
  input  logic [31:0]          ch_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 verify_err,
  output logic                 timeout_err,
  output logic [NUM_OF_CH-1:0] pll_status,
  output logic [NUM_OF_CH-1:0] ltr_status,
  output logic [3:0]           avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata
);

  lb_state_e                state_d, state_q;
  logic [LB_CSR_DW-1:0]     want_d, want_q;
  logic [NUM_OF_CH-1:0]     req_d, req_q;
  logic [NUM_OF_CH-1:0]     pll_d, pll_q;
  logic [NUM_OF_CH-1:0]     ltr_d, ltr_q;
  logic                     lpbk_d, lpbk_q;
  logic                     pass_d, pass_q;
  logic                     verr_d, verr_q;
  logic                     tmo_d, tmo_q;

  logic                     tmo_load;
  logic                     tmo_hit;
  logic                     wait_done;
  logic [31:0]              wait_term;
  logic                     locked;

  assign locked = ((pll_q & req_q) == req_q) &&
                  ((avm_readdata[NUM_OF_CH-1:0] & req_q) == req_q);

  always_comb begin
    state_d       = state_q;
    want_d        = want_q;
    req_d         = req_q;
    pll_d         = pll_q;
    ltr_d         = ltr_q;
    lpbk_d        = lpbk_q;
    pass_d        = pass_q;
    verr_d        = verr_q;
    tmo_d         = tmo_q;
    tmo_load      = 1'b0;
    wait_term     = 32'(READ_LATENCY - 1);
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          want_d   = lpbk_en ? ch_mask : '0;
          req_d    = ch_mask[NUM_OF_CH-1:0];
          lpbk_d   = lpbk_en;
          pass_d   = 1'b0;
          verr_d   = 1'b0;
          tmo_d    = 1'b0;
          tmo_load = 1'b1;
          state_d  = S_WR_CTRL;
        end
      end
      S_WR_CTRL: begin
        avm_write     = 1'b1;
        avm_address   = LB_ADDR_CTRL_WR;
        avm_writedata = want_q;
        state_d       = S_RD_CTRL;
      end
      S_RD_CTRL: begin
        avm_read    = 1'b1;
        avm_address = LB_ADDR_CTRL_RD;
        state_d     = S_WT_CTRL;
      end
      // The timeout budget is deliberately not consulted until the control word is verified.
      S_WT_CTRL: begin
        if (wait_done) begin
          if (avm_readdata != want_q) begin
            verr_d  = 1'b1;
            state_d = S_FIN;
          end else if (!lpbk_q) begin
            pass_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_RD_PLL;
          end
        end
      end
      S_RD_PLL: begin
        avm_read    = 1'b1;
        avm_address = LB_ADDR_PLL;
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_WT_PLL;
        end
      end
      S_WT_PLL: begin
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else if (wait_done) begin
          pll_d   = avm_readdata[NUM_OF_CH-1:0];
          state_d = S_RD_LTR;
        end
      end
      S_RD_LTR: begin
        avm_read    = 1'b1;
        avm_address = LB_ADDR_LTR;
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_WT_LTR;
        end
      end
      // A successful evaluation outranks a timeout landing in the same cycle.
      S_WT_LTR: begin
        if (wait_done) begin
          ltr_d = avm_readdata[NUM_OF_CH-1:0];
          if (locked) begin
            pass_d  = 1'b1;
            state_d = S_FIN;
          end else if (tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_GAP;
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_GAP: begin
        wait_term = 32'(POLL_GAP - 1);
        if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else if (wait_done) begin
          state_d = S_RD_PLL;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      want_q  <= '0;
      req_q   <= '0;
      pll_q   <= '0;
      ltr_q   <= '0;
      lpbk_q  <= 1'b0;
      pass_q  <= 1'b0;
      verr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      want_q  <= want_d;
      req_q   <= req_d;
      pll_q   <= pll_d;
      ltr_q   <= ltr_d;
      lpbk_q  <= lpbk_d;
      pass_q  <= pass_d;
      verr_q  <= verr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Restarting on every state change makes the count 0 in the first cycle of each state.
  lb_cycle_counter #(.WIDTH(32)) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state_d != state_q),
    .en       (busy),
    .load_val (32'd0),
    .term_val (wait_term),
    .at_term  (wait_done)
  );

  lb_cycle_counter #(.WIDTH(32)) u_tmo_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmo_load),
    .en       (busy),
    .load_val (32'd0),
    .term_val (32'(TIMEOUT_CYCLES)),
    .at_term  (tmo_hit)
  );

  assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done        = (state_q == S_FIN);
  assign pass        = pass_q;
  assign verify_err  = verr_q;
  assign timeout_err = tmo_q;
  assign pll_status  = pll_q;
  assign ltr_status  = ltr_q;

endmodule

// File: tb/tb_loopback_csr_sequencer.sv
// Bench for loopback_csr_sequencer: loopback CSR responder model plus a bus-transaction scoreboard.
module tb_loopback_csr_sequencer;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           lpbk_en = 1'b0;
  logic [31:0]    ch_mask = '0;
  logic           busy, done, pass, verify_err, timeout_err;
  logic [NCH-1:0] pll_status, ltr_status;
  logic [3:0]     avm_address;
  logic           avm_read, avm_write;
  logic [31:0]    avm_writedata, avm_readdata;

  always #5 clk = ~clk;

  loopback_csr_sequencer #(
    .NUM_OF_CH      (NCH),
    .READ_LATENCY   (1),
    .POLL_GAP       (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .lpbk_en       (lpbk_en),
    .ch_mask       (ch_mask),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .verify_err    (verify_err),
    .timeout_err   (timeout_err),
    .pll_status    (pll_status),
    .ltr_status    (ltr_status),
    .avm_address   (avm_address),
    .avm_read      (avm_read),
    .avm_write     (avm_write),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata)
  );

  // Responder: one-cycle read latency, junk on readdata whenever no read is returning.
  logic [31:0] r_ctrl = '0;
  logic [31:0] r_pll = '0;
  logic [31:0] r_ltr_good = '0;
  logic [31:0] r_ltr_bad = '0;
  logic [31:0] r_corrupt_val = '0;
  logic        r_corrupt = 1'b0;
  int          r_ltr_reads = 0;
  int          r_bad_limit = 0;

  always @(posedge clk) begin
    if (avm_write && avm_address == 4'd1) r_ctrl <= avm_writedata;
    if (avm_read) begin
      case (avm_address)
        4'd0: avm_readdata <= r_corrupt ? r_corrupt_val : r_ctrl;
        4'd1: avm_readdata <= r_pll;
        4'd2: begin
          avm_readdata <= (r_ltr_reads < r_bad_limit) ? r_ltr_bad : r_ltr_good;
          r_ltr_reads  <= r_ltr_reads + 1;
        end
        default: avm_readdata <= 32'h0;
      endcase
    end else begin
      avm_readdata <= 32'hDEAD_BEEF;
    end
  end

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] cyc;
  } bus_t;

  bus_t exp_q[$];
  bus_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cyc;

  // Cycle 0 is the cycle start is high; records every strobe with its cycle until done.
  task automatic run_cmd(input logic en, input logic [31:0] mask, input int restart_at,
                         input int budget);
    @(negedge clk);
    lpbk_en = en;
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ch_mask  = 32'hFFFF_FFFF;
    lpbk_en  = ~en;
    done_cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      if (avm_write || avm_read)
        obs_q.push_back('{avm_write, avm_address, avm_writedata, 16'(n)});
      if (done) begin
        done_cyc = n;
        break;
      end
      @(negedge clk);
      start = (n + 1 == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d, input int c);
    exp_q.push_back('{1'b1, 4'd1, d, 16'(c)});
  endtask

  task automatic push_rd(input logic [3:0] a, input int c);
    exp_q.push_back('{1'b0, a, 32'h0, 16'(c)});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, verify_err, timeout_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, verify_err, timeout_err});
    end
    n_cmp++;
    if ({avm_read, avm_write, avm_address, avm_writedata} !== 38'b0) begin
      n_bad++;
      $display("FAIL reset_bus: got rd=%b wr=%b addr=%h data=%h want all 0",
               avm_read, avm_write, avm_address, avm_writedata);
    end
    n_cmp++;
    if ({pll_status, ltr_status} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_status: got %h want 00", {pll_status, ltr_status});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_basic();
    bus_t e, o;
    r_pll = 32'hF; r_ltr_good = 32'hF; r_bad_limit = r_ltr_reads;
    push_wr(32'h5, 1); push_rd(4'd0, 2); push_rd(4'd1, 4); push_rd(4'd2, 6);
    run_cmd(1'b1, 32'h5, 0, 40);
    n_cmp++;
    if (done_cyc != 8) begin n_bad++; $display("FAIL lock_done_cycle: got %0d want 8", done_cyc); end
    n_cmp++;
    if ({pass, verify_err, timeout_err} !== 3'b100) begin
      n_bad++; $display("FAIL lock_flags: got %b want 100", {pass, verify_err, timeout_err});
    end
    n_cmp++;
    if ({pll_status, ltr_status} !== 8'hFF) begin
      n_bad++; $display("FAIL lock_status: got %h want ff", {pll_status, ltr_status});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL lock_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL lock_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL lock_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_disable();
    bus_t e, o;
    push_wr(32'h0, 1); push_rd(4'd0, 2);
    run_cmd(1'b0, 32'hF, 0, 40);
    n_cmp++;
    if (done_cyc != 4) begin n_bad++; $display("FAIL dis_done_cycle: got %0d want 4", done_cyc); end
    n_cmp++;
    if ({pass, verify_err, timeout_err} !== 3'b100) begin
      n_bad++; $display("FAIL dis_flags: got %b want 100", {pass, verify_err, timeout_err});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL dis_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL dis_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL dis_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_verify_err();
    bus_t e, o;
    r_corrupt = 1'b1; r_corrupt_val = 32'h4;
    push_wr(32'h5, 1); push_rd(4'd0, 2);
    run_cmd(1'b1, 32'h5, 0, 40);
    r_corrupt = 1'b0;
    n_cmp++;
    if (done_cyc != 4) begin n_bad++; $display("FAIL verr_done_cycle: got %0d want 4", done_cyc); end
    n_cmp++;
    if ({pass, verify_err, timeout_err} !== 3'b010) begin
      n_bad++; $display("FAIL verr_flags: got %b want 010", {pass, verify_err, timeout_err});
    end
    n_cmp++;
    if (pll_status !== 4'hF) begin n_bad++; $display("FAIL verr_status_hold: got %h want f", pll_status); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL verr_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL verr_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL verr_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_poll_rounds();
    bus_t e, o;
    r_pll = 32'hF; r_ltr_bad = 32'h1; r_ltr_good = 32'hF; r_bad_limit = r_ltr_reads + 3;
    push_wr(32'h3, 1); push_rd(4'd0, 2);
    // Each round: RD_PLL, WT_PLL, RD_LTR, WT_LTR, then 4 GAP cycles.
    for (int k = 0; k < 4; k++) begin
      push_rd(4'd1, 4 + 8 * k);
      push_rd(4'd2, 6 + 8 * k);
    end
    run_cmd(1'b1, 32'h3, 0, 100);
    n_cmp++;
    if (done_cyc != 32) begin n_bad++; $display("FAIL poll_done_cycle: got %0d want 32", done_cyc); end
    n_cmp++;
    if ({pass, verify_err, timeout_err} !== 3'b100) begin
      n_bad++; $display("FAIL poll_flags: got %b want 100", {pass, verify_err, timeout_err});
    end
    n_cmp++;
    if (ltr_status !== 4'hF) begin n_bad++; $display("FAIL poll_ltr_status: got %h want f", ltr_status); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL poll_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL poll_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL poll_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    bus_t e, o;
    r_pll = 32'h0; r_ltr_good = 32'hF; r_bad_limit = r_ltr_reads;
    push_wr(32'hF, 1); push_rd(4'd0, 2);
    // Counter is 0 in cycle 1 and reaches 50 in cycle 51 (a GAP cycle), so FIN is cycle 52.
    for (int k = 0; k < 6; k++) begin
      push_rd(4'd1, 4 + 8 * k);
      push_rd(4'd2, 6 + 8 * k);
    end
    run_cmd(1'b1, 32'hF, 0, 100);
    n_cmp++;
    if (done_cyc != 52) begin n_bad++; $display("FAIL tmo_done_cycle: got %0d want 52", done_cyc); end
    n_cmp++;
    if ({pass, verify_err, timeout_err} !== 3'b001) begin
      n_bad++; $display("FAIL tmo_flags: got %b want 001", {pass, verify_err, timeout_err});
    end
    r_pll = 32'hF;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, timeout_err, pass, pll_status} !== 7'b0100000) begin
      n_bad++;
      $display("FAIL tmo_after: got busy=%b tmo=%b pass=%b pll=%h want 0 1 0 0",
               busy, timeout_err, pass, pll_status);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL tmo_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL tmo_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL tmo_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_start_while_busy();
    bus_t e, o;
    int   idle_bad;
    r_pll = 32'hF; r_ltr_good = 32'hF; r_bad_limit = r_ltr_reads;
    push_wr(32'h5, 1); push_rd(4'd0, 2); push_rd(4'd1, 4); push_rd(4'd2, 6);
    run_cmd(1'b1, 32'h5, 3, 40);
    n_cmp++;
    if (done_cyc != 8) begin n_bad++; $display("FAIL busy_done_cycle: got %0d want 8", done_cyc); end
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || avm_read || avm_write || done) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin n_bad++; $display("FAIL busy_idle_after: got %0d active cycles want 0", idle_bad); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL busy_bus: missing addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL busy_bus: got wr=%0b addr=%0d data=%h cyc=%0d want wr=%0b addr=%0d data=%h cyc=%0d",
                   o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL busy_bus: %0d extra, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int act;
    r_pll = 32'hF; r_ltr_good = 32'hF; r_bad_limit = r_ltr_reads;
    @(negedge clk);
    lpbk_en = 1'b1; ch_mask = 32'h5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!busy || avm_read || avm_write) begin
      n_bad++; $display("FAIL rst_mid_precond: got busy=%b rd=%b wr=%b want 1 0 0", busy, avm_read, avm_write);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, avm_read, avm_write, avm_address, done} !== 8'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got busy=%b rd=%b wr=%b addr=%h done=%b want 0",
               busy, avm_read, avm_write, avm_address, done);
    end
    act = 0;
    repeat (2) begin @(negedge clk); if (done || busy) act++; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) act++; end
    n_cmp++;
    if (act != 0) begin n_bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", act); end
    n_cmp++;
    if ({pass, pll_status} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid_cleared: got pass=%b pll=%h want 0 0", pass, pll_status);
    end
    run_cmd(1'b1, 32'h5, 0, 40);
    obs_q.delete();
    n_cmp++;
    if (done_cyc != 8 || pass !== 1'b1 || pll_status !== 4'hF) begin
      n_bad++;
      $display("FAIL rst_mid_rerun: got done@%0d pass=%b pll=%h want done@8 pass=1 pll=f",
               done_cyc, pass, pll_status);
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_disable();
    test_verify_err();
    test_poll_rounds();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
